// File: rtl/img_ram_arbiter.sv
// Single-port image RAM arbiter for host, coprocessor read and coprocessor write.
// Default is fixed priority cp_wr > cp_rd > host; define ARB_ROUND_ROBIN_EN for rotating priority.
module img_ram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cp_rd_req,
  input  logic [ADDR_W-1:0] cp_rd_addr,
  output logic              cp_rd_gnt,
  output logic              cp_rd_valid,
  output logic [DATA_W-1:0] cp_rd_data,
  input  logic              cp_wr_req,
  input  logic [ADDR_W-1:0] cp_wr_addr,
  input  logic [DATA_W-1:0] cp_wr_data,
  output logic              cp_wr_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  // Bit positions of the requesters in every 3-bit request/grant vector.
  typedef enum logic [1:0] {
    SRC_CP_WR = 2'd0,
    SRC_CP_RD = 2'd1,
    SRC_HOST  = 2'd2
  } src_e;

  logic [2:0]        gnt_q;
  logic [2:0]        win_d;
  logic [2:0]        elig;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_we_q;
  logic [1:0]        rd_tag;
  logic [1:0]        tag_q [RD_LAT];
  logic              tag_any;
  logic              host_rvalid_q;
  logic              cp_rd_valid_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic [DATA_W-1:0] cp_rd_data_q;

  // A port granted this cycle still shows req for the access already issued.
  assign elig[SRC_CP_WR] = cp_wr_req & ~gnt_q[SRC_CP_WR];
  assign elig[SRC_CP_RD] = cp_rd_req & ~gnt_q[SRC_CP_RD];
  assign elig[SRC_HOST]  = host_req  & ~gnt_q[SRC_HOST];

`ifdef ARB_ROUND_ROBIN_EN
  src_e       ptr_q;
  src_e       ptr_d;
  logic [5:0] elig_rot;
  logic [5:0] win_unrot;
  logic [2:0] rot_win;

  // Rotate so the pointed-to port sits at bit 0, take the lowest set bit, rotate back.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    elig_rot  = {elig, elig} >> ptr_q;
    rot_win   = elig_rot[2:0] & (~elig_rot[2:0] + 3'd1);
    win_unrot = {rot_win, rot_win} << ptr_q;
    win_d     = win_unrot[5:3];
    ptr_d     = ptr_q;
    if (win_d[SRC_CP_WR])      ptr_d = SRC_CP_RD;
    else if (win_d[SRC_CP_RD]) ptr_d = SRC_HOST;
    else if (win_d[SRC_HOST])  ptr_d = SRC_CP_WR;
  end

  always_ff @(posedge clk_50M) begin
    if (!reset) ptr_q <= SRC_CP_WR;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_d            = '0;
    win_d[SRC_CP_WR] = elig[SRC_CP_WR];
    win_d[SRC_CP_RD] = elig[SRC_CP_RD] & ~elig[SRC_CP_WR];
    win_d[SRC_HOST]  = elig[SRC_HOST]  & ~elig[SRC_CP_RD] & ~elig[SRC_CP_WR];
  end
`endif

  // Reads issued this cycle enter the tag pipeline; writes never return data.
  assign rd_tag = {gnt_q[SRC_CP_RD], gnt_q[SRC_HOST] & ~ram_we_q};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      gnt_q         <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      host_rvalid_q <= 1'b0;
      cp_rd_valid_q <= 1'b0;
      host_rdata_q  <= '0;
      cp_rd_data_q  <= '0;
    end else begin
      gnt_q    <= win_d;
      ram_we_q <= 1'b0;
      if (win_d[SRC_CP_WR]) begin
        ram_addr_q  <= cp_wr_addr;
        ram_wdata_q <= cp_wr_data;
        ram_we_q    <= 1'b1;
      end else if (win_d[SRC_CP_RD]) begin
        ram_addr_q  <= cp_rd_addr;
      end else if (win_d[SRC_HOST]) begin
        ram_addr_q  <= host_addr;
        ram_wdata_q <= host_wdata;
        ram_we_q    <= host_we;
      end

      tag_q[0] <= rd_tag;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];

      host_rvalid_q <= tag_q[RD_LAT-1][0];
      cp_rd_valid_q <= tag_q[RD_LAT-1][1];
      if (tag_q[RD_LAT-1][0]) host_rdata_q <= ram_q;
      if (tag_q[RD_LAT-1][1]) cp_rd_data_q <= ram_q;
    end
  end

  always_comb begin
    tag_any = 1'b0;
    for (int i = 0; i < RD_LAT; i++) tag_any = tag_any | (|tag_q[i]);
  end

  assign cp_wr_gnt   = gnt_q[SRC_CP_WR];
  assign cp_rd_gnt   = gnt_q[SRC_CP_RD];
  assign host_gnt    = gnt_q[SRC_HOST];
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  // A write already on the RAM port when reset is asserted must not land.
  assign ram_we      = ram_we_q & reset;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign cp_rd_valid = cp_rd_valid_q;
  assign cp_rd_data  = cp_rd_data_q;
  assign busy        = (|gnt_q) | tag_any;

endmodule
